converge_ctrl_credit: RTL and testbench
=======================================

Name: converge_ctrl_credit

Overview:
- Next-generation leaf-side stream merger between a leaf's input/output port clusters and the BFT switch.
- Merges freespace-update packets from NUM_IN_PORTS input ports and data packets from NUM_OUT_PORTS output-port FIFOs onto one registered o_stream.
- Adds per-output-port credit flow control, replenished by credit packets arriving on i_stream.
- Adds round-robin fairness within each class and a bounded freespace-priority burst to prevent data starvation.

Parameters:
- PACKET_BITS, 97, packet width.
- NUM_LEAF_BITS, 6, destination leaf field width.
- NUM_PORT_BITS, 4, destination port field width.
- PAYLOAD_BITS, 64, payload field width.
- NUM_IN_PORTS, 7, number of freespace-update sources.
- NUM_OUT_PORTS, 7, number of data FIFO sources.
- CREDIT_BITS, 8, credit counter width.
- INIT_CREDITS, 64, per-port credit value after reset.
- CREDIT_PORT, 0, port-field value marking an incoming credit packet.
- FS_BURST_MAX, 4, maximum consecutive freespace grants while data is eligible.

Ports:
- clk, in, 1, clock.
- reset_n, in, 1, asynchronous active-low reset.
- i_bft_ready, in, 1, switch accepts o_stream this cycle.
- i_stream, in, PACKET_BITS, incoming packet from switch; inspected for credit packets only.
- o_stream, out, PACKET_BITS, registered outgoing packet; bit PACKET_BITS-1 is valid.
- i_fs_valid, in, NUM_IN_PORTS, freespace packet pending per input port.
- i_fs_packet, in, PACKET_BITS*NUM_IN_PORTS, freespace packets; port k at slice k.
- o_fs_ack, out, NUM_IN_PORTS, one-cycle consume pulse.
- i_out_empty, in, NUM_OUT_PORTS, FWFT FIFO empty flags.
- i_out_packet, in, PACKET_BITS*NUM_OUT_PORTS, FWFT FIFO heads.
- o_out_rd_en, out, NUM_OUT_PORTS, one-cycle pop pulse.
- i_port_enable, in, NUM_OUT_PORTS, per-port send enable.
- o_credit, out, CREDIT_BITS*NUM_OUT_PORTS, current credit counts.

Behaviour:
- Packet fields:
  - valid = [PACKET_BITS-1].
  - leaf = next NUM_LEAF_BITS below valid.
  - port = next NUM_PORT_BITS below leaf.
  - payload = [PAYLOAD_BITS-1:0].
- Reset (async assert, sync release):
  - o_stream = 0.
  - o_fs_ack = 0, o_out_rd_en = 0.
  - Credits = INIT_CREDITS.
  - Both RR pointers = 0, burst counter = 0.
  - A held packet is discarded.
- Output register slot is free when o_stream.valid==0, or when o_stream.valid==1 and i_bft_ready==1.
- HOLD: valid && !ready.
  - o_stream holds unchanged.
  - No grants; all acks and rd_ens stay 0.
- Eligibility:
  - fs[k] = i_fs_valid[k].
  - data[j] = !i_out_empty[j] && i_port_enable[j] && credit[j]!=0.
- Grant, computed combinationally in the same cycle as a free slot:
  - Grant freespace when any fs is eligible and (no data is eligible or burst < FS_BURST_MAX).
  - Otherwise grant data if any is eligible.
  - Otherwise load o_stream = 0.
- Round robin per class:
  - Search starts at pointer; the first eligible index wins.
  - After a grant, pointer = winner+1, wrapping modulo the port count.
- On grant:
  - Winner packet is registered into o_stream with valid forced to 1.
  - The matching o_fs_ack or o_out_rd_en pulses high in that same cycle; at most one pulse per cycle.
  - Latency from eligibility to o_stream valid is 1 cycle.
  - Back-to-back grants are allowed when i_bft_ready stays high.
- Burst counter:
  - Increments (saturating) on a freespace grant while any data is eligible.
  - Clears on any data grant, or on a cycle with no eligible data.
- Credit packet detection:
  - Condition: i_stream.valid && port==CREDIT_PORT.
  - idx = payload[NUM_PORT_BITS-1:0].
  - amt = payload[NUM_PORT_BITS+CREDIT_BITS-1:NUM_PORT_BITS].
  - idx >= NUM_OUT_PORTS: packet ignored.
- Credit update per port:
  - next = credit - rd_en[j] + inc[j], computed at CREDIT_BITS+1 width.
  - Saturates at 2^CREDIT_BITS-1.
  - A simultaneous decrement and increment on the same port both apply in that cycle.
- Credit arithmetic invariant: credit never decrements below 0, because eligibility already requires credit != 0.
- Port disable while a packet is held: the held packet still completes.
- Data packets never modify credits except through the rd_en decrement.

Decomposition:
- Shared package (bft_pkg):
  - Field offset/width functions for valid, leaf, port and payload.
  - CREDIT_PORT default.
  - Credit-packet payload layout constants.
- One sub-module: rr_arbiter.
  - Parameter N.
  - Inputs: request vector and an advance strobe.
  - Outputs: one-hot grant and a valid flag.
  - Owns its pointer register.
  - Instantiated twice: freespace class and data class.

Test Plan:
- Reset, then FIFO 2 non-empty with i_bft_ready=1.
  - Required: o_out_rd_en=0000100 for one cycle; o_stream = FIFO2 head with valid=1 the next cycle; credit[2] = 63.
- FIFOs 0, 3, 5 continuously non-empty, ready held high.
  - Required: grant order 0, 3, 5, 0, 3.
- i_bft_ready=0 for 5 cycles while fs[1] and data[0] are pending.
  - Required: o_stream is stable and no acks are issued.
  - On ready, the held packet is accepted and the next grant is fs[1].
- All 7 fs_valid held high with data[4] eligible and FS_BURST_MAX=4.
  - Required: 4 freespace grants, then 1 data[4] grant, repeating.
- credit[6] drained to 0 with FIFO 6 non-empty.
  - Required: no rd_en[6].
  - Then a credit packet arrives: port=0, idx=6, amt=10.
  - Required: credit[6]=10 next cycle, and FIFO 6 resumes.
- credit[1] = 250 and a credit packet with amt=20 arrives in the same cycle as rd_en[1].
  - Required: credit[1]=255 (saturated).
  - Also: a credit packet with idx=9 leaves all credits unchanged.

Source files
------------

// File: rtl/bft_pkg.sv
// Shared packet-field layout and credit-packet constants for the leaf-side BFT blocks.
// Field positions are derived from the packet/field widths so every block agrees on them.
package bft_pkg;

    localparam int CREDIT_PORT_DEFAULT = 0;
    localparam int CREDIT_IDX_LSB      = 0;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_FS   = 2'd1,
        GRANT_DATA = 2'd2
    } grant_kind_e;

    function automatic int valid_bit(input int packetBits);
        return packetBits - 1;
    endfunction

    function automatic int leaf_lsb(input int packetBits, input int leafBits);
        return packetBits - 1 - leafBits;
    endfunction

    function automatic int port_lsb(input int packetBits, input int leafBits, input int portBits);
        return leaf_lsb(packetBits, leafBits) - portBits;
    endfunction

    function automatic int payload_lsb();
        return 0;
    endfunction

    // Credit payload: port index in the low bits, credit amount directly above it.
    function automatic int credit_amt_lsb(input int portBits);
        return CREDIT_IDX_LSB + portBits;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at the pointer, the first requester wins,
// and on an accepted grant the pointer moves just past the winner.
module rr_arbiter #(
    parameter int N = 7
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] i_req,
    input  logic         i_advance,
    output logic [N-1:0] o_grant,
    output logic         o_valid
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] winIdx;
    logic [PW:0]   cand;
    logic          found;

    always_comb begin
        o_grant = '0;
        winIdx  = ptr_q;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(i);
            if (cand >= (PW+1)'(N)) begin
                cand = cand - (PW+1)'(N);
            end
            if (!found && i_req[cand[PW-1:0]]) begin
                found                 = 1'b1;
                winIdx                = cand[PW-1:0];
                o_grant[cand[PW-1:0]] = 1'b1;
            end
        end
    end

    assign o_valid = found;

    always_comb begin
        ptr_d = ptr_q;
        if (i_advance && found) begin
            ptr_d = (winIdx == PW'(N-1)) ? '0 : winIdx + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/converge_ctrl_credit.sv
// Leaf-side stream merger: freespace updates and credit-gated data packets share one
// registered output, with per-class round robin and a bounded freespace burst.
module converge_ctrl_credit
    import bft_pkg::*;
#(
    parameter int PACKET_BITS   = 97,
    parameter int NUM_LEAF_BITS = 6,
    parameter int NUM_PORT_BITS = 4,
    parameter int PAYLOAD_BITS  = 64,
    parameter int NUM_IN_PORTS  = 7,
    parameter int NUM_OUT_PORTS = 7,
    parameter int CREDIT_BITS   = 8,
    parameter int INIT_CREDITS  = 64,
    parameter int CREDIT_PORT   = CREDIT_PORT_DEFAULT,
    parameter int FS_BURST_MAX  = 4
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   i_bft_ready,
    input  logic [PACKET_BITS-1:0]                 i_stream,
    output logic [PACKET_BITS-1:0]                 o_stream,
    input  logic [NUM_IN_PORTS-1:0]                i_fs_valid,
    input  logic [PACKET_BITS*NUM_IN_PORTS-1:0]    i_fs_packet,
    output logic [NUM_IN_PORTS-1:0]                o_fs_ack,
    input  logic [NUM_OUT_PORTS-1:0]               i_out_empty,
    input  logic [PACKET_BITS*NUM_OUT_PORTS-1:0]   i_out_packet,
    output logic [NUM_OUT_PORTS-1:0]               o_out_rd_en,
    input  logic [NUM_OUT_PORTS-1:0]               i_port_enable,
    output logic [CREDIT_BITS*NUM_OUT_PORTS-1:0]   o_credit
);

    localparam int VALID_BIT   = valid_bit(PACKET_BITS);
    localparam int PORT_LSB    = port_lsb(PACKET_BITS, NUM_LEAF_BITS, NUM_PORT_BITS);
    localparam int PAYLOAD_LSB = payload_lsb();
    localparam int AMT_LSB     = credit_amt_lsb(NUM_PORT_BITS);
    localparam int BURST_BITS  = $clog2(FS_BURST_MAX + 1);

    logic [PACKET_BITS-1:0]  stream_q;
    logic [PACKET_BITS-1:0]  stream_d;
    logic [CREDIT_BITS-1:0]  credit_q [NUM_OUT_PORTS];
    logic [CREDIT_BITS-1:0]  credit_d [NUM_OUT_PORTS];
    logic [BURST_BITS-1:0]   burst_q;
    logic [BURST_BITS-1:0]   burst_d;

    logic [NUM_OUT_PORTS-1:0] dataElig;
    logic [NUM_IN_PORTS-1:0]  fsGrant;
    logic [NUM_OUT_PORTS-1:0] dataGrant;
    logic                     fsAny;
    logic                     dataAny;
    logic                     slotFree;
    grant_kind_e              grantKind;
    logic [PACKET_BITS-1:0]   fsPkt;
    logic [PACKET_BITS-1:0]   dataPkt;

    logic [PAYLOAD_BITS-1:0]  payload;
    logic                     creditHit;
    logic [NUM_PORT_BITS-1:0] creditIdx;
    logic [CREDIT_BITS-1:0]   creditAmt;
    logic [CREDIT_BITS:0]     creditSum [NUM_OUT_PORTS];
    logic                     unusedStreamBits;

    always_comb begin
        for (int j = 0; j < NUM_OUT_PORTS; j++) begin
            dataElig[j] = !i_out_empty[j] && i_port_enable[j] && (credit_q[j] != '0);
        end
    end

    rr_arbiter #(.N(NUM_IN_PORTS)) fsArb (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_req     (i_fs_valid),
        .i_advance (grantKind == GRANT_FS),
        .o_grant   (fsGrant),
        .o_valid   (fsAny)
    );

    rr_arbiter #(.N(NUM_OUT_PORTS)) dataArb (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_req     (dataElig),
        .i_advance (grantKind == GRANT_DATA),
        .o_grant   (dataGrant),
        .o_valid   (dataAny)
    );

    assign slotFree = !stream_q[VALID_BIT] || i_bft_ready;

    // Freespace normally wins, but only for a bounded run while data is waiting.
    always_comb begin
        grantKind = GRANT_NONE;
        if (reset_n && slotFree) begin
            if (fsAny && (!dataAny || burst_q < BURST_BITS'(FS_BURST_MAX))) begin
                grantKind = GRANT_FS;
            end else if (dataAny) begin
                grantKind = GRANT_DATA;
            end
        end
    end

    assign o_fs_ack    = (grantKind == GRANT_FS)   ? fsGrant   : '0;
    assign o_out_rd_en = (grantKind == GRANT_DATA) ? dataGrant : '0;

    always_comb begin
        fsPkt   = '0;
        dataPkt = '0;
        for (int k = 0; k < NUM_IN_PORTS; k++) begin
            if (fsGrant[k]) begin
                fsPkt = fsPkt | i_fs_packet[k*PACKET_BITS +: PACKET_BITS];
            end
        end
        for (int j = 0; j < NUM_OUT_PORTS; j++) begin
            if (dataGrant[j]) begin
                dataPkt = dataPkt | i_out_packet[j*PACKET_BITS +: PACKET_BITS];
            end
        end
    end

    always_comb begin
        stream_d = stream_q;
        if (slotFree) begin
            case (grantKind)
                GRANT_FS:   stream_d = fsPkt;
                GRANT_DATA: stream_d = dataPkt;
                default:    stream_d = '0;
            endcase
            if (grantKind != GRANT_NONE) begin
                stream_d[VALID_BIT] = 1'b1;
            end
        end
    end

    always_comb begin
        burst_d = burst_q;
        if (!dataAny || grantKind == GRANT_DATA) begin
            burst_d = '0;
        end else if (grantKind == GRANT_FS && burst_q < BURST_BITS'(FS_BURST_MAX)) begin
            burst_d = burst_q + BURST_BITS'(1);
        end
    end

    assign payload   = i_stream[PAYLOAD_LSB +: PAYLOAD_BITS];
    assign creditHit = i_stream[VALID_BIT] &&
                       (i_stream[PORT_LSB +: NUM_PORT_BITS] == NUM_PORT_BITS'(CREDIT_PORT));
    assign creditIdx = payload[CREDIT_IDX_LSB +: NUM_PORT_BITS];
    assign creditAmt = payload[AMT_LSB +: CREDIT_BITS];

    assign unusedStreamBits = ^{i_stream[VALID_BIT-1:PORT_LSB+NUM_PORT_BITS],
                                i_stream[PORT_LSB-1:PAYLOAD_BITS],
                                payload[PAYLOAD_BITS-1:AMT_LSB+CREDIT_BITS]};

    // One extra bit of headroom lets a pop and a refill land together before saturating.
    always_comb begin
        for (int j = 0; j < NUM_OUT_PORTS; j++) begin
            creditSum[j] = {1'b0, credit_q[j]}
                         - {{CREDIT_BITS{1'b0}}, o_out_rd_en[j]}
                         + ((creditHit && creditIdx == NUM_PORT_BITS'(j)) ? {1'b0, creditAmt} : '0);
            credit_d[j]  = creditSum[j][CREDIT_BITS] ? '1 : creditSum[j][CREDIT_BITS-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stream_q <= '0;
            burst_q  <= '0;
            for (int j = 0; j < NUM_OUT_PORTS; j++) begin
                credit_q[j] <= CREDIT_BITS'(INIT_CREDITS);
            end
        end else begin
            stream_q <= stream_d;
            burst_q  <= burst_d;
            for (int j = 0; j < NUM_OUT_PORTS; j++) begin
                credit_q[j] <= credit_d[j];
            end
        end
    end

    assign o_stream = stream_q;

    always_comb begin
        o_credit = '0;
        for (int j = 0; j < NUM_OUT_PORTS; j++) begin
            o_credit[j*CREDIT_BITS +: CREDIT_BITS] = credit_q[j];
        end
    end

endmodule

// File: tb/tb_converge_ctrl_credit.sv
// Self-checking bench for converge_ctrl_credit: directed scenarios plus randomized traffic,
// all compared against a queue-free behavioural model of the merge/credit rules.
module tb_converge_ctrl_credit;

    localparam int PB        = 97;
    localparam int LB        = 6;
    localparam int NPB       = 4;
    localparam int NI        = 7;
    localparam int NO        = 7;
    localparam int CB        = 8;
    localparam int VB        = PB - 1;
    localparam int PORT_LSB  = PB - 1 - LB - NPB;
    localparam int BURST_MAX = 4;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               i_bft_ready;
    logic [PB-1:0]      i_stream;
    logic [PB-1:0]      o_stream;
    logic [NI-1:0]      i_fs_valid;
    logic [PB*NI-1:0]   i_fs_packet;
    logic [NI-1:0]      o_fs_ack;
    logic [NO-1:0]      i_out_empty;
    logic [PB*NO-1:0]   i_out_packet;
    logic [NO-1:0]      o_out_rd_en;
    logic [NO-1:0]      i_port_enable;
    logic [CB*NO-1:0]   o_credit;

    logic [PB-1:0] fsPkt   [NI];
    logic [PB-1:0] dataPkt [NO];

    int            mCredit [NO];
    logic [CB*NO-1:0] mCreditVec;
    int            mFsPtr, mDataPtr, mBurst;
    logic [PB-1:0] mOut;
    logic [NI-1:0] eAck;
    logic [NO-1:0] eRd;
    logic [PB-1:0] eNext;
    int            eKind, eWin;
    bit            eAnyData;
    int            eInc [NO];
    logic [NI-1:0] obsAck;
    logic [NO-1:0] obsRd;

    int errors = 0;
    int checks = 0;

    converge_ctrl_credit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_bft_ready   (i_bft_ready),
        .i_stream      (i_stream),
        .o_stream      (o_stream),
        .i_fs_valid    (i_fs_valid),
        .i_fs_packet   (i_fs_packet),
        .o_fs_ack      (o_fs_ack),
        .i_out_empty   (i_out_empty),
        .i_out_packet  (i_out_packet),
        .o_out_rd_en   (o_out_rd_en),
        .i_port_enable (i_port_enable),
        .o_credit      (o_credit)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NI; k++) i_fs_packet[k*PB +: PB] = fsPkt[k];
        for (int j = 0; j < NO; j++) i_out_packet[j*PB +: PB] = dataPkt[j];
    end

    function automatic logic [PB-1:0] randPkt();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[PB-1:0];
    endfunction

    function automatic logic [PB-1:0] makeCredit(input int idx, input int amt);
        logic [PB-1:0] p;
        p = randPkt();
        p[VB] = 1'b1;
        p[PORT_LSB +: NPB] = '0;
        p[NPB-1:0] = idx[NPB-1:0];
        p[NPB +: CB] = amt[CB-1:0];
        return p;
    endfunction

    // Model: eligibility and winners straight from the merge rules, using integer pointers.
    task automatic modelPredict();
        bit free, anyF;
        int w, idx;
        eAck = '0; eRd = '0; eKind = 0; eWin = -1; eNext = mOut;
        anyF = |i_fs_valid;
        eAnyData = 1'b0;
        for (int j = 0; j < NO; j++)
            if (!i_out_empty[j] && i_port_enable[j] && mCredit[j] > 0) eAnyData = 1'b1;
        free = !mOut[VB] || i_bft_ready;
        if (free) begin
            eNext = '0;
            if (anyF && (!eAnyData || mBurst < BURST_MAX)) begin
                for (int s = 0; s < NI; s++) begin
                    w = (mFsPtr + s) % NI;
                    if (eWin < 0 && i_fs_valid[w]) eWin = w;
                end
                eKind = 1; eAck[eWin] = 1'b1; eNext = fsPkt[eWin]; eNext[VB] = 1'b1;
            end else if (eAnyData) begin
                for (int s = 0; s < NO; s++) begin
                    w = (mDataPtr + s) % NO;
                    if (eWin < 0 && !i_out_empty[w] && i_port_enable[w] && mCredit[w] > 0) eWin = w;
                end
                eKind = 2; eRd[eWin] = 1'b1; eNext = dataPkt[eWin]; eNext[VB] = 1'b1;
            end
        end
        for (int j = 0; j < NO; j++) eInc[j] = 0;
        idx = int'(i_stream[NPB-1:0]);
        if (i_stream[VB] && i_stream[PORT_LSB +: NPB] == '0 && idx < NO)
            eInc[idx] = int'(i_stream[NPB +: CB]);
    endtask

    task automatic modelCommit();
        int c;
        mOut = eNext;
        if (eKind == 1) mFsPtr = (eWin + 1) % NI;
        if (eKind == 2) mDataPtr = (eWin + 1) % NO;
        if (eKind == 2 || !eAnyData) mBurst = 0;
        else if (eKind == 1 && mBurst < BURST_MAX) mBurst = mBurst + 1;
        for (int j = 0; j < NO; j++) begin
            c = mCredit[j] - int'(eRd[j]) + eInc[j];
            if (c > 255) c = 255;
            mCredit[j] = c;
            mCreditVec[j*CB +: CB] = c[CB-1:0];
        end
        for (int j = 0; j < NO; j++) if (eRd[j]) dataPkt[j] = randPkt();
        for (int k = 0; k < NI; k++) if (eAck[k]) fsPkt[k] = randPkt();
    endtask

    task automatic modelReset();
        mOut = '0; mFsPtr = 0; mDataPtr = 0; mBurst = 0;
        for (int j = 0; j < NO; j++) begin
            mCredit[j] = 64;
            mCreditVec[j*CB +: CB] = 8'd64;
        end
    endtask

    task automatic runCycle();
        @(negedge clk);
        modelPredict();
        obsAck = o_fs_ack;
        obsRd  = o_out_rd_en;
        @(posedge clk);
        #1;
        modelCommit();
    endtask

    task automatic idleInputs();
        i_bft_ready = 1'b0; i_stream = '0; i_fs_valid = '0;
        i_out_empty = '1; i_port_enable = '1;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        idleInputs();
        for (int k = 0; k < NI; k++) fsPkt[k] = randPkt();
        for (int j = 0; j < NO; j++) dataPkt[j] = randPkt();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        modelReset();
    endtask

    task automatic test_reset();
        doReset();
        reset_n = 1'b0;
        i_fs_valid = '1; i_out_empty = '0; i_bft_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (o_stream !== '0) begin errors++; $display("[TB] FAIL reset o_stream: got %h want 0", o_stream); end
        checks++; if (o_fs_ack !== '0) begin errors++; $display("[TB] FAIL reset fs_ack: got %b want 0", o_fs_ack); end
        checks++; if (o_out_rd_en !== '0) begin errors++; $display("[TB] FAIL reset rd_en: got %b want 0", o_out_rd_en); end
        checks++; if (o_credit !== {7{8'd64}}) begin errors++; $display("[TB] FAIL reset credit: got %h want all 40", o_credit); end
        idleInputs();
        @(posedge clk); #1;
        reset_n = 1'b1;
        modelReset();
        i_bft_ready = 1'b1; i_out_empty = ~7'b0000001;
        runCycle();
        i_out_empty = '1;
        checks++; if (o_stream !== mOut) begin errors++; $display("[TB] FAIL reset preload: got %h want %h", o_stream, mOut); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (o_stream !== '0) begin errors++; $display("[TB] FAIL async clear o_stream: got %h want 0", o_stream); end
        checks++; if (o_credit !== {7{8'd64}}) begin errors++; $display("[TB] FAIL async clear credit: got %h want all 40", o_credit); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        modelReset();
    endtask

    task automatic test_single_data();
        logic [PB-1:0] expPkt;
        doReset();
        i_bft_ready = 1'b1; i_out_empty = ~7'b0000100;
        expPkt = dataPkt[2]; expPkt[VB] = 1'b1;
        runCycle();
        i_out_empty = '1;
        checks++; if (obsRd !== 7'b0000100) begin errors++; $display("[TB] FAIL single rd_en: got %b want 0000100", obsRd); end
        checks++; if (o_stream !== expPkt) begin errors++; $display("[TB] FAIL single o_stream: got %h want %h", o_stream, expPkt); end
        checks++; if (o_credit[2*CB +: CB] !== 8'd63) begin errors++; $display("[TB] FAIL single credit2: got %0d want 63", o_credit[2*CB +: CB]); end
        runCycle();
        checks++; if (obsRd !== '0) begin errors++; $display("[TB] FAIL single second rd_en: got %b want 0", obsRd); end
        checks++; if (o_stream !== '0) begin errors++; $display("[TB] FAIL single drain o_stream: got %h want 0", o_stream); end
    endtask

    task automatic test_rr_order();
        int expOrder [5] = '{0, 3, 5, 0, 3};
        int got;
        doReset();
        i_bft_ready = 1'b1; i_out_empty = ~7'b0101001;
        for (int c = 0; c < 5; c++) begin
            runCycle();
            got = -1;
            for (int j = 0; j < NO; j++) if (obsRd[j]) got = j;
            checks++; if (got != expOrder[c]) begin errors++; $display("[TB] FAIL rr order[%0d]: got %0d want %0d", c, got, expOrder[c]); end
            checks++; if (o_stream !== mOut) begin errors++; $display("[TB] FAIL rr o_stream[%0d]: got %h want %h", c, o_stream, mOut); end
        end
    endtask

    task automatic test_hold();
        logic [PB-1:0] held, expPkt;
        doReset();
        i_bft_ready = 1'b1; i_out_empty = ~7'b0001000;
        runCycle();
        held = mOut;
        i_out_empty = ~7'b0000001; i_fs_valid = 7'b0000010; i_bft_ready = 1'b0;
        i_port_enable = 7'b1110111;
        for (int c = 0; c < 5; c++) begin
            runCycle();
            checks++; if (o_stream !== held) begin errors++; $display("[TB] FAIL hold stable[%0d]: got %h want %h", c, o_stream, held); end
            checks++; if (obsAck !== '0 || obsRd !== '0) begin errors++; $display("[TB] FAIL hold pulses[%0d]: got ack %b rd %b want 0", c, obsAck, obsRd); end
        end
        i_bft_ready = 1'b1;
        expPkt = fsPkt[1]; expPkt[VB] = 1'b1;
        runCycle();
        checks++; if (obsAck !== 7'b0000010) begin errors++; $display("[TB] FAIL hold release ack: got %b want 0000010", obsAck); end
        checks++; if (o_stream !== expPkt) begin errors++; $display("[TB] FAIL hold release o_stream: got %h want %h", o_stream, expPkt); end
    endtask

    task automatic test_burst();
        doReset();
        i_bft_ready = 1'b1; i_fs_valid = '1; i_out_empty = ~7'b0010000;
        for (int c = 0; c < 15; c++) begin
            runCycle();
            checks++; if (obsRd !== ((c % 5 == 4) ? 7'b0010000 : 7'b0)) begin errors++; $display("[TB] FAIL burst rd_en[%0d]: got %b", c, obsRd); end
            checks++; if ((|obsAck) !== (c % 5 != 4)) begin errors++; $display("[TB] FAIL burst ack[%0d]: got %b", c, obsAck); end
            checks++; if (obsAck !== eAck || o_stream !== mOut) begin errors++; $display("[TB] FAIL burst model[%0d]: got ack %b stream %h want ack %b stream %h", c, obsAck, o_stream, eAck, mOut); end
        end
    endtask

    task automatic test_credit_drain();
        doReset();
        i_bft_ready = 1'b1; i_out_empty = ~7'b1000000;
        for (int c = 0; c < 64; c++) begin
            runCycle();
            checks++; if (o_credit !== mCreditVec) begin errors++; $display("[TB] FAIL drain credit[%0d]: got %h want %h", c, o_credit, mCreditVec); end
        end
        runCycle();
        checks++; if (obsRd !== '0) begin errors++; $display("[TB] FAIL drain zero rd_en: got %b want 0", obsRd); end
        checks++; if (o_credit[6*CB +: CB] !== 8'd0) begin errors++; $display("[TB] FAIL drain credit6: got %0d want 0", o_credit[6*CB +: CB]); end
        i_stream = makeCredit(6, 10);
        runCycle();
        i_stream = '0;
        checks++; if (o_credit[6*CB +: CB] !== 8'd10) begin errors++; $display("[TB] FAIL refill credit6: got %0d want 10", o_credit[6*CB +: CB]); end
        runCycle();
        checks++; if (obsRd !== 7'b1000000) begin errors++; $display("[TB] FAIL resume rd_en: got %b want 1000000", obsRd); end
        checks++; if (o_credit[6*CB +: CB] !== 8'd9) begin errors++; $display("[TB] FAIL resume credit6: got %0d want 9", o_credit[6*CB +: CB]); end
    endtask

    task automatic test_credit_saturate();
        logic [CB*NO-1:0] expVec;
        doReset();
        i_bft_ready = 1'b1;
        i_stream = makeCredit(1, 186);
        runCycle();
        checks++; if (o_credit[1*CB +: CB] !== 8'd250) begin errors++; $display("[TB] FAIL sat preload credit1: got %0d want 250", o_credit[1*CB +: CB]); end
        i_stream = makeCredit(1, 20); i_out_empty = ~7'b0000010;
        runCycle();
        i_out_empty = '1;
        checks++; if (obsRd !== 7'b0000010) begin errors++; $display("[TB] FAIL sat rd_en: got %b want 0000010", obsRd); end
        checks++; if (o_credit[1*CB +: CB] !== 8'd255) begin errors++; $display("[TB] FAIL sat credit1: got %0d want 255", o_credit[1*CB +: CB]); end
        expVec = {7{8'd64}};
        expVec[1*CB +: CB] = 8'd255;
        i_stream = makeCredit(9, 50);
        runCycle();
        i_stream = '0;
        checks++; if (o_credit !== expVec) begin errors++; $display("[TB] FAIL bad idx credit: got %h want %h", o_credit, expVec); end
    endtask

    task automatic test_random();
        doReset();
        for (int c = 0; c < 600; c++) begin
            i_bft_ready   = ($urandom_range(0, 3) != 0);
            i_fs_valid    = 7'($urandom()) & 7'($urandom());
            i_out_empty   = 7'($urandom());
            i_port_enable = 7'($urandom()) | 7'($urandom());
            i_stream      = ($urandom_range(0, 3) == 0) ? makeCredit($urandom_range(0, 9), $urandom_range(0, 255)) : randPkt();
            runCycle();
            checks++; if (obsAck !== eAck) begin errors++; $display("[TB] FAIL rand ack[%0d]: got %b want %b", c, obsAck, eAck); end
            checks++; if (obsRd !== eRd) begin errors++; $display("[TB] FAIL rand rd_en[%0d]: got %b want %b", c, obsRd, eRd); end
            checks++; if (o_stream !== mOut) begin errors++; $display("[TB] FAIL rand o_stream[%0d]: got %h want %h", c, o_stream, mOut); end
            checks++; if (o_credit !== mCreditVec) begin errors++; $display("[TB] FAIL rand credit[%0d]: got %h want %h", c, o_credit, mCreditVec); end
        end
        idleInputs();
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        idleInputs();
        test_reset();
        test_single_data();
        test_rr_order();
        test_hold();
        test_burst();
        test_credit_drain();
        test_credit_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
